// File: rtl/booth_mult_seq_if.sv
// Purpose : request/result bundle for the iterative Booth multiplier.
// Ports   : start/tc/M/Q flow from requester to multiplier; busy/done/P flow back.
// Modports: master = requester side, slave = multiplier side.
interface booth_mult_seq_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 tc;
   logic [WIDTH-1:0]     M;
   logic [WIDTH-1:0]     Q;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   P;

   modport master (
      output start, tc, M, Q,
      input  busy, done, P
   );

   modport slave (
      input  start, tc, M, Q,
      output busy, done, P
   );
endinterface

// File: rtl/booth_mult_seq.sv
// Purpose : iterative radix-2 Booth multiplier, one Booth step per clock, signed or unsigned.
// Latency : done pulses WIDTH+1 clocks after the edge that samples start; issue interval WIDTH+3.
// Backpr. : none queued; start is only looked at in IDLE, busy flags the RUN phase.
// Ports   : clk, rst (async, active-high); bus.slave carries start/tc/M/Q in and busy/done/P out.
module booth_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   booth_mult_seq_if.slave bus
);
   // One extra bit lets both signed and unsigned operands live in a single
   // signed datapath: the mode is folded into the extension at capture.
   localparam int N  = WIDTH + 1;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [N-1:0]        a;
   logic [N-1:0]        qr;
   logic                q_m1;
   logic [N-1:0]        m_ext;
   logic [CW-1:0]       count;
   logic                busy_r;
   logic                done_r;
   logic [2*WIDTH-1:0]  p_r;

   logic [N-1:0]        m_in;
   logic [N-1:0]        q_in;
   logic [N-1:0]        sum;
   logic [N-1:0]        a_next;
   logic [N-1:0]        qr_next;

   always_comb begin
      m_in = {bus.tc & bus.M[WIDTH-1], bus.M};
      q_in = {bus.tc & bus.Q[WIDTH-1], bus.Q};

      // Booth recoding of the pair {Q0, Q_-1}; A wraps at N bits.
      case ({qr[0], q_m1})
         2'b01:   sum = a + m_ext;
         2'b10:   sum = a - m_ext;
         default: sum = a;
      endcase

      // Arithmetic right shift of {A, Qreg, Q_-1}; Q_-1 takes qr[0] in the FSM.
      a_next  = {sum[N-1], sum[N-1:1]};
      qr_next = {sum[0], qr[N-1:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a      <= '0;
         qr     <= '0;
         q_m1   <= 1'b0;
         m_ext  <= '0;
         count  <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         p_r    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  m_ext  <= m_in;
                  qr     <= q_in;
                  a      <= '0;
                  q_m1   <= 1'b0;
                  count  <= '0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               a     <= a_next;
               qr    <= qr_next;
               q_m1  <= qr[0];
               count <= count + 1'b1;
               if (count == CW'(N - 1)) begin
                  // Low 2*WIDTH bits of the 2N-bit {A, Qreg}: the top two
                  // bits of A are pure sign/overflow and are dropped.
                  p_r    <= {a_next[N-3:0], qr_next};
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.P    = p_r;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Purpose : self-checking bench for booth_mult_seq at WIDTH 8, 12 and 16.
// Latency : expects done exactly WIDTH+1 clocks after the start edge.
// Backpr. : exercises held start, ignored start during RUN/DONE and async reset.
module tb_booth_mult_seq;
   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   booth_mult_seq_if #(.WIDTH(8))  if8  ();
   booth_mult_seq_if #(.WIDTH(12)) if12 ();
   booth_mult_seq_if #(.WIDTH(16)) if16 ();

   booth_mult_seq #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .bus(if8.slave));
   booth_mult_seq #(.WIDTH(12)) u_w12 (.clk(clk), .rst(rst), .bus(if12.slave));
   booth_mult_seq #(.WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .bus(if16.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer multiply of the operands interpreted per tc,
   // reduced to the 2w-bit product width.
   function automatic logic [63:0] ref_prod(int w, logic t, logic [31:0] m, logic [31:0] q);
      longint mask;
      longint mm;
      longint qq;
      longint prod;
      mask = (longint'(1) << w) - 1;
      mm   = longint'(m) & mask;
      qq   = longint'(q) & mask;
      if (t) begin
         if (mm >= (longint'(1) << (w - 1))) mm = mm - (longint'(1) << w);
         if (qq >= (longint'(1) << (w - 1))) qq = qq - (longint'(1) << w);
      end
      prod = (mm * qq) & ((longint'(1) << (2 * w)) - 1);
      return 64'(prod);
   endfunction

   task automatic set_in(int sel, logic s, logic t, logic [31:0] m, logic [31:0] q);
      case (sel)
         8:  begin if8.start  = s; if8.tc  = t; if8.M  = m[7:0];  if8.Q  = q[7:0];  end
         12: begin if12.start = s; if12.tc = t; if12.M = m[11:0]; if12.Q = q[11:0]; end
         default: begin if16.start = s; if16.tc = t; if16.M = m[15:0]; if16.Q = q[15:0]; end
      endcase
   endtask

   task automatic get_out(int sel, output logic b, output logic d, output logic [63:0] p);
      case (sel)
         8:  begin b = if8.busy;  d = if8.done;  p = 64'(if8.P);  end
         12: begin b = if12.busy; d = if12.done; p = 64'(if12.P); end
         default: begin b = if16.busy; d = if16.done; p = 64'(if16.P); end
      endcase
   endtask

   // Issues one request and observes a bounded window after the start edge.
   // lat = posedges from the start edge to the edge that raised done (-1 if never).
   task automatic run_op(int sel, logic t, logic [31:0] m, logic [31:0] q,
                         output logic [63:0] p_done, output logic [63:0] p_end,
                         output int lat, output int bcnt, output int dcnt);
      logic b;
      logic d;
      logic [63:0] p;
      lat = -1; bcnt = 0; dcnt = 0; p_done = '0; p = '0;
      @(negedge clk);
      set_in(sel, 1'b1, t, m, q);
      @(posedge clk);
      for (int k = 1; k <= sel + 5; k++) begin
         @(negedge clk);
         // Scramble operands after capture: they must not affect the result.
         if (k == 1) set_in(sel, 1'b0, ~t, ~m, ~q);
         get_out(sel, b, d, p);
         if (b) bcnt++;
         if (d) begin
            dcnt++;
            if (lat < 0) begin
               lat = k - 1;
               p_done = p;
            end
         end
      end
      p_end = p;
   endtask

   task automatic test_reset;
      logic b;
      logic d;
      logic [63:0] p;
      rst = 1'b1;
      set_in(8, 1'b0, 1'b0, 0, 0);
      set_in(12, 1'b0, 1'b0, 0, 0);
      set_in(16, 1'b0, 1'b0, 0, 0);
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         int sel;
         sel = (s == 0) ? 8 : (s == 1) ? 12 : 16;
         get_out(sel, b, d, p);
         checks++;
         if ({b, d} !== 2'b00 || p !== 64'd0) begin
            errors++;
            $display("FAIL reset_w%0d: busy=%b done=%b P=%h, expected 0 0 0", sel, b, d, p);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_signed_basic;
      int ms [5] = '{0, 10, -12, 7, -8};
      int qs [5] = '{0, 5, 3, -4, -8};
      logic [63:0] ex [5] = '{64'd0, 64'd50, 64'hFFDC, 64'hFFE4, 64'd64};
      logic [63:0] pd, pe;
      int lat, bc, dc;
      for (int i = 0; i < 5; i++) begin
         run_op(8, 1'b1, ms[i], qs[i], pd, pe, lat, bc, dc);
         checks++;
         if (pd !== ex[i]) begin
            errors++;
            $display("FAIL basic_p[%0d]: got %h expected %h", i, pd, ex[i]);
         end
         checks++;
         if (lat !== 9) begin
            errors++;
            $display("FAIL basic_lat[%0d]: got %0d expected 9", i, lat);
         end
         checks++;
         if (bc !== 9) begin
            errors++;
            $display("FAIL basic_busy[%0d]: got %0d cycles expected 9", i, bc);
         end
         checks++;
         if (dc !== 1) begin
            errors++;
            $display("FAIL basic_done_width[%0d]: got %0d cycles expected 1", i, dc);
         end
         checks++;
         if (pe !== ex[i]) begin
            errors++;
            $display("FAIL basic_hold[%0d]: got %h expected %h", i, pe, ex[i]);
         end
      end
   endtask

   task automatic test_corners8;
      logic        ts [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      int          ms [4] = '{-128, -128, 255, 200};
      int          qs [4] = '{-128, 127, 255, 3};
      logic [63:0] ex [4] = '{64'h4000, 64'hC080, 64'hFE01, 64'd600};
      logic [63:0] pd, pe;
      int lat, bc, dc;
      for (int i = 0; i < 4; i++) begin
         run_op(8, ts[i], ms[i], qs[i], pd, pe, lat, bc, dc);
         checks++;
         if (pd !== ex[i] || lat !== 9) begin
            errors++;
            $display("FAIL corner8[%0d]: got P=%h lat=%0d expected P=%h lat=9", i, pd, lat, ex[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic b, d, released;
      logic [63:0] p, p1, p2;
      int first, second, dc;
      first = -1; second = -1; dc = 0; released = 1'b0; p1 = '0; p2 = '0;
      @(negedge clk);
      set_in(8, 1'b1, 1'b1, 6, 7);
      @(posedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) set_in(8, 1'b1, 1'b1, 9, 9);
         get_out(8, b, d, p);
         if (d) begin
            dc++;
            if (first < 0) begin first = k; p1 = p; end
            else if (second < 0) begin second = k; p2 = p; end
         end
         if (b && first > 0 && !released) begin
            set_in(8, 1'b0, 1'b1, 9, 9);
            released = 1'b1;
         end
      end
      checks++;
      if (p1 !== 64'd42) begin
         errors++;
         $display("FAIL b2b_first: got %h expected %h", p1, 64'd42);
      end
      checks++;
      if (p2 !== 64'd81) begin
         errors++;
         $display("FAIL b2b_second: got %h expected %h", p2, 64'd81);
      end
      checks++;
      if (dc !== 2) begin
         errors++;
         $display("FAIL b2b_done_count: got %0d expected 2", dc);
      end
      checks++;
      if (first !== 10 || second - first !== 11) begin
         errors++;
         $display("FAIL b2b_timing: first=%0d interval=%0d expected 10 and 11", first, second - first);
      end
   endtask

   task automatic test_reset_mid;
      logic b, d;
      logic [63:0] p, pd, pe;
      int dc, lat, bc;
      dc = 0;
      @(negedge clk);
      set_in(8, 1'b1, 1'b1, -5, 11);
      @(posedge clk);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) set_in(8, 1'b0, 1'b1, -5, 11);
      end
      rst = 1'b1;
      #1;
      get_out(8, b, d, p);
      checks++;
      if ({b, d} !== 2'b00 || p !== 64'd0) begin
         errors++;
         $display("FAIL rst_mid_async: busy=%b done=%b P=%h expected 0 0 0", b, d, p);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         get_out(8, b, d, p);
         if (d) dc++;
      end
      checks++;
      if (dc !== 0 || p !== 64'd0) begin
         errors++;
         $display("FAIL rst_mid_no_done: done pulses=%0d P=%h expected 0 and 0", dc, p);
      end
      run_op(8, 1'b1, 3, -3, pd, pe, lat, bc, dc);
      checks++;
      if (pd !== 64'hFFF7 || lat !== 9) begin
         errors++;
         $display("FAIL rst_mid_after: got P=%h lat=%0d expected P=%h lat=9", pd, lat, 64'hFFF7);
      end
   endtask

   task automatic test_wide16;
      logic [63:0] pd, pe;
      int lat, bc, dc;
      run_op(16, 1'b1, -32768, -32768, pd, pe, lat, bc, dc);
      checks++;
      if (pd !== 64'h40000000 || lat !== 17) begin
         errors++;
         $display("FAIL w16_signed: got P=%h lat=%0d expected P=%h lat=17", pd, lat, 64'h40000000);
      end
      run_op(16, 1'b0, 65535, 65535, pd, pe, lat, bc, dc);
      checks++;
      if (pd !== 64'hFFFE0001 || lat !== 17) begin
         errors++;
         $display("FAIL w16_unsigned: got P=%h lat=%0d expected P=%h lat=17", pd, lat, 64'hFFFE0001);
      end
   endtask

   task automatic test_random;
      logic [63:0] pd, pe, ex;
      logic [31:0] m, q;
      logic t;
      int lat, bc, dc, sel;
      for (int i = 0; i < 1000; i++) begin
         sel = (i % 2 == 0) ? 8 : 12;
         t   = 1'($urandom_range(0, 1));
         m   = $urandom;
         q   = $urandom;
         ex  = ref_prod(sel, t, m, q);
         run_op(sel, t, m, q, pd, pe, lat, bc, dc);
         checks++;
         if (pd !== ex) begin
            errors++;
            $display("FAIL rand_p[%0d] w=%0d tc=%b M=%h Q=%h: got %h expected %h", i, sel, t, m, q, pd, ex);
         end
         checks++;
         if (lat !== sel + 1) begin
            errors++;
            $display("FAIL rand_lat[%0d] w=%0d: got %0d expected %0d", i, sel, lat, sel + 1);
         end
      end
   endtask

   initial begin
      test_reset;
      test_signed_basic;
      test_corners8;
      test_back_to_back;
      test_reset_mid;
      test_wide16;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
